// File: rtl/sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_motion_ctrl
//  Description : Per-frame sprite position controller. During vertical
//                blanking (once every FRAME_DIV accepted frames) it adds a
//                signed velocity to the sprite position, bounces off the
//                screen edges by clamping and negating that velocity axis,
//                and publishes the new position in a single commit cycle so
//                the renderer sees a stable position for the visible frame.
//  Ports       : clk, rst_n           - pixel clock, async active-low reset
//                i_frame              - 1-cycle pulse at start of vblank
//                i_enable             - motion allowed (0: frames ignored)
//                i_load               - 1-cycle pulse: load velocity
//                i_dx_in / i_dy_in    - signed velocity to load
//                o_sprx / o_spry      - signed sprite position to renderer
//                o_bounce_x/_y        - 1-cycle pulse: edge hit this update
//                o_busy               - update in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_motion_ctrl #(
    parameter int CORDW      = 16,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int SPR_WIDTH  = 32,
    parameter int SPR_HEIGHT = 20,
    parameter int SPR_SCALE  = 0,
    parameter int SPEED_W    = 4,
    parameter int FRAME_DIV  = 1,
    parameter int X0         = 0,
    parameter int Y0         = 0,
    parameter int VX0        = 1,
    parameter int VY0        = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_frame,
    input  logic                      i_enable,
    input  logic                      i_load,
    input  logic signed [SPEED_W-1:0] i_dx_in,
    input  logic signed [SPEED_W-1:0] i_dy_in,
    output logic signed [CORDW-1:0]   o_sprx,
    output logic signed [CORDW-1:0]   o_spry,
    output logic                      o_bounce_x,
    output logic                      o_bounce_y,
    output logic                      o_busy
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [DIV_W-1:0]          c_DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic signed [CORDW:0]     c_XMAX = (CORDW+1)'(H_RES - (SPR_WIDTH  << SPR_SCALE));
    localparam logic signed [CORDW:0]     c_YMAX = (CORDW+1)'(V_RES - (SPR_HEIGHT << SPR_SCALE));
    // Most negative velocity has no positive counterpart, so loads of it
    // are pulled in by one to keep negation exact.
    localparam logic signed [SPEED_W-1:0] c_VMIN = {1'b1, {(SPEED_W-1){1'b0}}};
    localparam logic signed [SPEED_W-1:0] c_VSAT = c_VMIN + 1'b1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC_X = 2'd1;
    localparam logic [1:0] S_CALC_Y = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]                r_state;
    logic [DIV_W-1:0]          r_div;
    logic signed [SPEED_W-1:0] r_vx;
    logic signed [SPEED_W-1:0] r_vy;
    logic signed [CORDW-1:0]   r_sprx;
    logic signed [CORDW-1:0]   r_spry;
    logic signed [CORDW-1:0]   r_nx;
    logic signed [CORDW-1:0]   r_ny;
    logic                      r_bx;
    logic                      r_by;
    logic                      r_bounce_x;
    logic                      r_bounce_y;

    // One adder/clamp shared by both axes: X is evaluated in CALC_X,
    // Y in CALC_Y.
    logic                      w_sel_y;
    logic signed [CORDW-1:0]   w_pos;
    logic signed [SPEED_W-1:0] w_vel;
    logic signed [CORDW:0]     w_max;
    logic signed [CORDW:0]     w_sum;
    logic                      w_lo;
    logic                      w_hi;
    logic                      w_hit;
    logic signed [CORDW-1:0]   w_next;
    logic signed [SPEED_W-1:0] w_ld_dx;
    logic signed [SPEED_W-1:0] w_ld_dy;

    assign w_sel_y = (r_state == S_CALC_Y);
    assign w_pos   = w_sel_y ? r_spry : r_sprx;
    assign w_vel   = w_sel_y ? r_vy   : r_vx;
    assign w_max   = w_sel_y ? c_YMAX : c_XMAX;

    assign w_sum   = $signed({w_pos[CORDW-1], w_pos})
                   + $signed({{(CORDW+1-SPEED_W){w_vel[SPEED_W-1]}}, w_vel});
    assign w_lo    = w_sum[CORDW];
    assign w_hi    = !w_sum[CORDW] && (w_sum > w_max);
    assign w_hit   = w_lo || w_hi;
    assign w_next  = w_lo ? '0 :
                     w_hi ? w_max[CORDW-1:0] :
                            w_sum[CORDW-1:0];

    assign w_ld_dx = (i_dx_in == c_VMIN) ? c_VSAT : i_dx_in;
    assign w_ld_dy = (i_dy_in == c_VMIN) ? c_VSAT : i_dy_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_vx       <= SPEED_W'(VX0);
            r_vy       <= SPEED_W'(VY0);
            r_sprx     <= CORDW'(X0);
            r_spry     <= CORDW'(Y0);
            r_nx       <= '0;
            r_ny       <= '0;
            r_bx       <= 1'b0;
            r_by       <= 1'b0;
            r_bounce_x <= 1'b0;
            r_bounce_y <= 1'b0;
        end else begin
            r_bounce_x <= 1'b0;
            r_bounce_y <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_frame && i_enable) begin
                        if (r_div == c_DIV_LAST) begin
                            r_div   <= '0;
                            r_state <= S_CALC_X;
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end
                end
                S_CALC_X: begin
                    r_nx    <= w_next;
                    r_bx    <= w_hit;
                    if (w_hit) begin
                        r_vx <= -r_vx;
                    end
                    r_state <= S_CALC_Y;
                end
                S_CALC_Y: begin
                    r_ny    <= w_next;
                    r_by    <= w_hit;
                    if (w_hit) begin
                        r_vy <= -r_vy;
                    end
                    r_state <= S_COMMIT;
                end
                default: begin
                    r_sprx     <= r_nx;
                    r_spry     <= r_ny;
                    r_bounce_x <= r_bx;
                    r_bounce_y <= r_by;
                    r_state    <= S_IDLE;
                end
            endcase
            // Placed after the FSM so a load overrides a same-cycle negation.
            if (i_load) begin
                r_vx <= w_ld_dx;
                r_vy <= w_ld_dy;
            end
        end
    end

    assign o_sprx     = r_sprx;
    assign o_spry     = r_spry;
    assign o_bounce_x = r_bounce_x;
    assign o_bounce_y = r_bounce_y;
    assign o_busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_motion_ctrl
//  Description : Self-checking bench for sprite_motion_ctrl. A transaction-
//                level model tracks position, velocity and frame divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_motion_ctrl;

    localparam int XMAX = 640 - 32;
    localparam int YMAX = 480 - 20;
    localparam int FD   = 2;
    localparam int PX0  = 100;
    localparam int PY0  = 50;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame;
    logic              enable;
    logic              load;
    logic signed [3:0] dx_in;
    logic signed [3:0] dy_in;
    logic signed [15:0] sprx;
    logic signed [15:0] spry;
    logic              bounce_x;
    logic              bounce_y;
    logic              busy;

    int n_total = 0;
    int n_bad   = 0;

    int m_x, m_y, m_vx, m_vy, m_div;

    sprite_motion_ctrl #(
        .CORDW(16), .H_RES(640), .V_RES(480), .SPR_WIDTH(32), .SPR_HEIGHT(20),
        .SPR_SCALE(0), .SPEED_W(4), .FRAME_DIV(FD), .X0(PX0), .Y0(PY0),
        .VX0(1), .VY0(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_frame(frame), .i_enable(enable),
        .i_load(load), .i_dx_in(dx_in), .i_dy_in(dy_in),
        .o_sprx(sprx), .o_spry(spry), .o_bounce_x(bounce_x),
        .o_bounce_y(bounce_y), .o_busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic void axis(input int p, input int v, input int mx,
                                 output int np, output int nv, output bit b);
        np = p + v;
        nv = v;
        b  = 1'b0;
        if (np < 0) begin
            np = 0; nv = -v; b = 1'b1;
        end else if (np > mx) begin
            np = mx; nv = -v; b = 1'b1;
        end
    endfunction

    function automatic int sat(input int d);
        return (d == -8) ? -7 : d;
    endfunction

    function automatic int clamp7(input int d);
        return (d > 7) ? 7 : (d < -7) ? -7 : d;
    endfunction

    task automatic model_reset();
        m_x = PX0; m_y = PY0; m_vx = 1; m_vy = 1; m_div = 0;
    endtask

    // ---------------- stimulus primitives ----------------
    task automatic load_vel(input int dx, input int dy);
        load  = 1'b1;
        dx_in = 4'(dx);
        dy_in = 4'(dy);
        @(negedge clk);
        load  = 1'b0;
        m_vx  = sat(dx);
        m_vy  = sat(dy);
    endtask

    // Issue one frame pulse from IDLE and check the full visible reaction.
    task automatic drive_frame(input bit en, output bit moved);
        int ex, ey, evx, evy;
        bit ebx, eby;
        moved  = 1'b0;
        frame  = 1'b1;
        enable = en;
        @(negedge clk);
        frame  = 1'b0;
        enable = 1'b1;
        if (en) begin
            if (m_div == FD - 1) begin
                moved = 1'b1;
                m_div = 0;
            end else begin
                m_div++;
            end
        end
        if (!moved) begin
            n_total++;
            if ({busy, sprx, spry} !== {1'b0, 16'(m_x), 16'(m_y)}) begin
                n_bad++;
                $display("FAIL no_move: busy=%0b x=%0d y=%0d required busy=0 x=%0d y=%0d",
                         busy, sprx, spry, m_x, m_y);
            end
            return;
        end
        axis(m_x, m_vx, XMAX, ex, evx, ebx);
        axis(m_y, m_vy, YMAX, ey, evy, eby);
        for (int c = 0; c < 3; c++) begin
            n_total++;
            if ({busy, sprx, spry} !== {1'b1, 16'(m_x), 16'(m_y)}) begin
                n_bad++;
                $display("FAIL busy_phase%0d: busy=%0b x=%0d y=%0d required busy=1 x=%0d y=%0d",
                         c, busy, sprx, spry, m_x, m_y);
            end
            if (c < 2) @(negedge clk);
        end
        @(negedge clk);
        n_total++;
        if ({busy, sprx, spry, bounce_x, bounce_y} !==
            {1'b0, 16'(ex), 16'(ey), ebx, eby}) begin
            n_bad++;
            $display("FAIL commit: busy=%0b x=%0d y=%0d bx=%0b by=%0b required busy=0 x=%0d y=%0d bx=%0b by=%0b",
                     busy, sprx, spry, bounce_x, bounce_y, ex, ey, ebx, eby);
        end
        @(negedge clk);
        n_total++;
        if ({bounce_x, bounce_y} !== 2'b00) begin
            n_bad++;
            $display("FAIL pulse_width: bx=%0b by=%0b required 0 0", bounce_x, bounce_y);
        end
        m_x = ex; m_y = ey; m_vx = evx; m_vy = evy;
    endtask

    task automatic move_once();
        bit mv;
        mv = 1'b0;
        while (!mv) drive_frame(1'b1, mv);
    endtask

    // Walk the sprite to an in-range target without touching an edge.
    task automatic goto_pos(input int tx, input int ty);
        while (m_x != tx || m_y != ty) begin
            load_vel(clamp7(tx - m_x), clamp7(ty - m_y));
            move_once();
        end
    endtask

    // Bring the divider to its last count so the next frame moves.
    task automatic arm_divider();
        bit mv;
        while (m_div != FD - 1) drive_frame(1'b1, mv);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_total++;
        if ({sprx, spry, busy, bounce_x, bounce_y} !==
            {16'(PX0), 16'(PY0), 3'b000}) begin
            n_bad++;
            $display("FAIL reset: x=%0d y=%0d busy=%0b bx=%0b by=%0b required x=%0d y=%0d 0 0 0",
                     sprx, spry, busy, bounce_x, bounce_y, PX0, PY0);
        end
    endtask

    task automatic test_basic_move();
        load_vel(2, 1);
        move_once();
        n_total++;
        if ({sprx, spry} !== {16'(PX0 + 2), 16'(PY0 + 1)}) begin
            n_bad++;
            $display("FAIL basic_move: x=%0d y=%0d required x=%0d y=%0d",
                     sprx, spry, PX0 + 2, PY0 + 1);
        end
    endtask

    task automatic test_right_edge();
        goto_pos(607, 200);
        load_vel(3, 0);
        move_once();
        n_total++;
        if (sprx !== 16'(XMAX)) begin
            n_bad++;
            $display("FAIL right_edge: x=%0d required %0d", sprx, XMAX);
        end
        move_once();
        n_total++;
        if (sprx !== 16'sd605) begin
            n_bad++;
            $display("FAIL right_rebound: x=%0d required 605", sprx);
        end
    endtask

    task automatic test_top_edge();
        goto_pos(300, 1);
        load_vel(0, -4);
        move_once();
        n_total++;
        if (spry !== 16'sd0) begin
            n_bad++;
            $display("FAIL top_edge: y=%0d required 0", spry);
        end
        move_once();
        n_total++;
        if (spry !== 16'sd4) begin
            n_bad++;
            $display("FAIL top_rebound: y=%0d required 4", spry);
        end
        // exact landing on an edge is not a bounce
        goto_pos(5, 300);
        load_vel(-5, 0);
        move_once();
        n_total++;
        if (m_vx !== -5 || sprx !== 16'sd0) begin
            n_bad++;
            $display("FAIL exact_edge: x=%0d required 0 with no bounce", sprx);
        end
    endtask

    task automatic test_corner();
        goto_pos(606, 2);
        load_vel(5, -5);
        move_once();
        n_total++;
        if ({sprx, spry} !== {16'(XMAX), 16'sd0}) begin
            n_bad++;
            $display("FAIL corner: x=%0d y=%0d required x=%0d y=0", sprx, spry, XMAX);
        end
    endtask

    task automatic test_divider_enable();
        bit mv;
        int moves;
        goto_pos(200, 200);
        load_vel(1, 1);
        moves = 0;
        for (int i = 0; i < 4; i++) begin
            drive_frame(1'b1, mv);
            if (mv) moves++;
        end
        n_total++;
        if (sprx !== 16'(200 + moves) || moves != 2) begin
            n_bad++;
            $display("FAIL divider: x=%0d required %0d", sprx, 202);
        end
        for (int i = 0; i < 3; i++) drive_frame(1'b0, mv);
        n_total++;
        if (sprx !== 16'sd202) begin
            n_bad++;
            $display("FAIL enable_off: x=%0d required 202", sprx);
        end
    endtask

    task automatic test_busy_frame();
        int ex, ey, evx, evy;
        bit ebx, eby, mv;
        arm_divider();
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b1;            // second pulse lands while busy
        @(negedge clk);
        frame = 1'b0;
        repeat (2) @(negedge clk);
        m_div = 0;
        axis(m_x, m_vx, XMAX, ex, evx, ebx);
        axis(m_y, m_vy, YMAX, ey, evy, eby);
        m_x = ex; m_y = ey; m_vx = evx; m_vy = evy;
        n_total++;
        if ({sprx, spry} !== {16'(m_x), 16'(m_y)}) begin
            n_bad++;
            $display("FAIL busy_frame_move: x=%0d y=%0d required x=%0d y=%0d",
                     sprx, spry, m_x, m_y);
        end
        // ignored pulse must not have advanced the divider
        drive_frame(1'b1, mv);
    endtask

    task automatic test_load_in_calc();
        int ex, ey, evx, evy;
        bit ebx, eby;
        goto_pos(605, 100);
        load_vel(6, 2);
        arm_divider();
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        load  = 1'b1;            // lands in CALC_X
        dx_in = -4'sd2;
        dy_in = -4'sd3;
        @(negedge clk);
        load  = 1'b0;
        repeat (2) @(negedge clk);
        m_div = 0;
        axis(m_x, m_vx, XMAX, ex, evx, ebx);
        evx = -2;
        axis(m_y, -3, YMAX, ey, evy, eby);
        m_x = ex; m_y = ey; m_vx = evx; m_vy = evy;
        n_total++;
        if ({sprx, spry, bounce_x} !== {16'(m_x), 16'(m_y), 1'b1}) begin
            n_bad++;
            $display("FAIL load_calc: x=%0d y=%0d bx=%0b required x=%0d y=%0d bx=1",
                     sprx, spry, bounce_x, m_x, m_y);
        end
        @(negedge clk);
        move_once();
        n_total++;
        if (sprx !== 16'sd606) begin
            n_bad++;
            $display("FAIL load_wins: x=%0d required 606", sprx);
        end
    endtask

    task automatic test_saturate();
        goto_pos(300, 300);
        load_vel(-8, -8);
        move_once();
        n_total++;
        if ({sprx, spry} !== {16'sd293, 16'sd293}) begin
            n_bad++;
            $display("FAIL saturate: x=%0d y=%0d required 293 293", sprx, spry);
        end
    endtask

    task automatic test_random();
        bit mv, en;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0)
                load_vel(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
            en = ($urandom_range(0, 3) != 0);
            drive_frame(en, mv);
        end
    endtask

    task automatic test_reset_mid_commit();
        goto_pos(400, 300);
        load_vel(3, 3);
        arm_divider();
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        repeat (2) @(negedge clk);   // now in COMMIT
        rst_n = 1'b0;
        #1;
        model_reset();
        n_total++;
        if ({sprx, spry, busy, bounce_x, bounce_y} !==
            {16'(PX0), 16'(PY0), 3'b000}) begin
            n_bad++;
            $display("FAIL reset_commit: x=%0d y=%0d busy=%0b required x=%0d y=%0d busy=0",
                     sprx, spry, busy, PX0, PY0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        move_once();
    endtask

    initial begin
        rst_n  = 1'b0;
        frame  = 1'b0;
        enable = 1'b1;
        load   = 1'b0;
        dx_in  = '0;
        dy_in  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_basic_move();
        test_right_edge();
        test_top_edge();
        test_corner();
        test_divider_enable();
        test_busy_frame();
        test_load_in_calc();
        test_saturate();
        test_random();
        test_reset_mid_commit();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
